// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and LSU results into one registered regfile write per cycle with fair LSU priority; `WB_BYPASS_EN adds write-bypass ports
module wb_arbiter #(
  parameter int ALU_FIFO_DEPTH = 4,
  parameter int MAX_LSU_STREAK = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alu_valid,
  input  logic [4:0]                        alu_rd,
  input  logic [31:0]                       alu_result,
  output logic                              alu_ready,
  input  logic                              lsu_valid,
  input  logic [4:0]                        lsu_rd,
  input  logic [31:0]                       lsu_data,
  output logic                              lsu_ready,
  output logic                              we,
  output logic [4:0]                        wa,
  output logic [31:0]                       wd,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   alu_fifo_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]                        byp_ra1,
  input  logic [4:0]                        byp_ra2,
  output logic                              byp_hit1,
  output logic                              byp_hit2,
  output logic [31:0]                       byp_data1,
  output logic [31:0]                       byp_data2
`endif
);
  localparam int AW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  logic [4:0]    fifo_rd   [ALU_FIFO_DEPTH];
  logic [31:0]   fifo_data [ALU_FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [SW-1:0] streak;
  logic          fifo_ne, cand, force_alu, lsu_win, alu_win, win, pop, push;
  logic [4:0]    cand_rd, win_rd;
  logic [31:0]   cand_data, win_data;
  assign fifo_ne   = alu_fifo_count != '0;
  assign alu_ready = alu_fifo_count < CW'(ALU_FIFO_DEPTH);
  assign cand      = fifo_ne || alu_valid;
  assign cand_rd   = fifo_ne ? fifo_rd[rptr] : alu_rd;
  assign cand_data = fifo_ne ? fifo_data[rptr] : alu_result;
  assign force_alu = streak == SW'(MAX_LSU_STREAK) && cand;
  assign lsu_ready = !force_alu;
  assign lsu_win   = lsu_valid && !force_alu;
  assign alu_win   = !lsu_win && cand;
  assign win       = lsu_win || alu_win;
  assign win_rd    = lsu_win ? lsu_rd : cand_rd;
  assign win_data  = lsu_win ? lsu_data : cand_data;
  assign pop       = alu_win && fifo_ne;
  assign push      = alu_valid && alu_ready && !(alu_win && !fifo_ne);
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= alu_rd;
      fifo_data[wptr] <= alu_result;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we             <= 1'b0;
      wa             <= '0;
      wd             <= '0;
      rptr           <= '0;
      wptr           <= '0;
      alu_fifo_count <= '0;
      streak         <= '0;
    end else begin
      we <= win && win_rd != '0;
      if (win && win_rd != '0) begin
        wa <= win_rd;
        wd <= win_data;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      alu_fifo_count <= alu_fifo_count + CW'(push) - CW'(pop);
      streak         <= (lsu_win && cand) ? streak + SW'(streak != SW'(MAX_LSU_STREAK)) : '0;
    end
  end
`ifdef WB_BYPASS_EN
  assign byp_hit1  = we && wa == byp_ra1 && byp_ra1 != '0;
  assign byp_hit2  = we && wa == byp_ra2 && byp_ra2 != '0;
  assign byp_data1 = byp_hit1 ? wd : '0;
  assign byp_data2 = byp_hit2 ? wd : '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter arbitration, fairness, FIFO order, x0 drop and reset
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_result = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  alu_fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_ra1 = '0, byp_ra2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif
  logic [36:0] alu_q [$];
  int          n_checks = 0, n_pass = 0;
  logic        alu_acc, lsu_acc;
  always #5 clk = ~clk;
  wb_arbiter #(.ALU_FIFO_DEPTH(4), .MAX_LSU_STREAK(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we(we), .wa(wa), .wd(wd), .alu_fifo_count(alu_fifo_count)
`ifdef WB_BYPASS_EN
    , .byp_ra1(byp_ra1), .byp_ra2(byp_ra2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    logic [36:0] lsu_w;
    logic [36:0] e;
    lsu_acc = lsu_valid && lsu_ready && !reset;
    alu_acc = alu_valid && alu_ready && !reset;
    lsu_w   = {lsu_rd, lsu_data};
    if (alu_acc && alu_rd != '0) alu_q.push_back({alu_rd, alu_result});
    @(posedge clk);
    #1;
    if (reset) begin
      alu_q.delete();
      check("reset_we", {63'd0, we}, 64'd0);
    end else if (lsu_acc && lsu_w[36:32] != '0) begin
      check("lsu_write", {26'd0, we, wa, wd}, {26'd0, 1'b1, lsu_w});
    end else if (we) begin
      if (alu_q.size() == 0) check("unexpected_write", {26'd0, we, wa, wd}, 64'd0);
      else begin
        e = alu_q.pop_front();
        check("alu_write", {26'd0, we, wa, wd}, {26'd0, 1'b1, e});
      end
    end
  endtask
  initial begin
    int idx, cyc, nl;
    logic exp_rdy [6];
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    step();
    step();
    reset = 1'b0;
    check("rst_count", 64'(alu_fifo_count), 64'd0);
    check("rst_wa_wd", {27'd0, wa, wd}, 64'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hDEADBEEF;
    step();
    lsu_valid = 1'b0;
    step();
    check("t1_we_off", {63'd0, we}, 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    step();
    check("t2_count1", 64'(alu_fifo_count), 64'd1);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    check("t2_alu_we", {58'd0, we, wa}, {58'd0, 1'b1, 5'd1});
    check("t2_count0", 64'(alu_fifo_count), 64'd0);
    nl = 0;
    lsu_valid = 1'b1; lsu_rd = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h33;
    for (int i = 0; i < 6; i++) begin
      lsu_data = 32'h700 + nl;
      check($sformatf("t3_lsu_ready%0d", i), {63'd0, lsu_ready}, {63'd0, exp_rdy[i]});
      step();
      if (i == 0) check("t3_alu_acc", {63'd0, alu_acc}, 64'd1);
      alu_valid = 1'b0;
      if (lsu_acc) nl++;
    end
    check("t3_lsu_count", 64'(nl), 64'd5);
    idx = 0; cyc = 0;
    lsu_rd = 5'd9;
    while ((idx < 6 || alu_q.size() != 0 || alu_fifo_count != '0) && cyc < 200) begin
      alu_valid  = idx < 6;
      alu_rd     = 5'(10 + idx);
      alu_result = 32'h4000 + idx;
      lsu_data   = 32'h900 + cyc;
      if (alu_fifo_count == 3'd4) check("t4_full_not_ready", {63'd0, alu_ready}, 64'd0);
      step();
      if (alu_acc) idx++;
      cyc++;
    end
    check("t4_drained", 64'(cyc < 200), 64'd1);
    check("t4_all_issued", 64'(idx), 64'd6);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hFFFFFFFF;
    step();
    check("t5_x0_acc", {63'd0, alu_acc}, 64'd1);
    check("t5_x0_we", {63'd0, we}, 64'd0);
    alu_valid = 1'b0;
    step();
    check("t5_count", 64'(alu_fifo_count), 64'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd4;
    alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(20 + i); alu_result = 32'h6000 + i; lsu_data = 32'h600 + i;
      step();
    end
    check("t6_count3", 64'(alu_fifo_count), 64'd3);
    alu_valid = 1'b0; lsu_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_count0", 64'(alu_fifo_count), 64'd0);
    for (int i = 0; i < 4; i++) step();
    check("t6_no_write", {63'd0, we}, 64'd0);
`ifdef WB_BYPASS_EN
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hA5;
    byp_ra1 = 5'd5; byp_ra2 = 5'd6;
    step();
    lsu_valid = 1'b0;
    #1;
    check("byp_hit1", {63'd0, byp_hit1}, 64'd1);
    check("byp_data1", 64'(byp_data1), 64'hA5);
    check("byp_hit2", {63'd0, byp_hit2}, 64'd0);
    check("byp_data2", 64'(byp_data2), 64'd0);
    step();
    check("byp_idle", {63'd0, byp_hit1}, 64'd0);
`endif
    check("sb_empty", 64'(alu_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
